// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int XLEN_C     = 32;
    localparam int AW_C       = 5;
    localparam int NUM_REGS_C = 32;

    // One buffered writeback request.
    typedef struct packed {
        logic [AW_C-1:0]   addr;
        logic [XLEN_C-1:0] data;
    } wb_req_t;

    // Writeback source identity; also used to remember the last contended winner.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot with a valid/ready input handshake.
// The slot frees when granted and may be refilled on that same edge.
module rf_wb_slot #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [XLEN-1:0] in_data,
    input  logic            grant,
    output logic            full,
    output logic [AW-1:0]   addr,
    output logic [XLEN-1:0] data,
    output logic            fill
);

    // Accept when empty or draining this cycle; never accept while in reset.
    assign in_ready = rst_n & (~full | grant);
    assign fill     = in_valid & in_ready;

    // Slot register: capture on accept, empty on grant without refill.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (fill) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the ALU (source 0)
// and the load unit (source 1). Round-robin between distinct registers,
// oldest-first when both slots target the same register.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [AW-1:0]     s0_addr,
    input  logic [XLEN-1:0]   s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [AW-1:0]     s1_addr,
    input  logic [XLEN-1:0]   s1_data,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wR,
    output logic [XLEN-1:0]   rf_wD,
    output logic [2**AW-1:0]  busy_mask,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic            full0, full1;
    logic [AW-1:0]   addr0, addr1;
    logic [XLEN-1:0] data0, data1;
    logic            fill0, fill1;
    logic            grant0, grant1;
    logic            any_full, both_full;
    wb_src_e         win;
    wb_src_e         last_grant;
    logic            older_is_1;

    rf_wb_slot #(.XLEN(XLEN), .AW(AW)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s0_valid),
        .in_ready (s0_ready),
        .in_addr  (s0_addr),
        .in_data  (s0_data),
        .grant    (grant0),
        .full     (full0),
        .addr     (addr0),
        .data     (data0),
        .fill     (fill0)
    );

    rf_wb_slot #(.XLEN(XLEN), .AW(AW)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_ready (s1_ready),
        .in_addr  (s1_addr),
        .in_data  (s1_data),
        .grant    (grant1),
        .full     (full1),
        .addr     (addr1),
        .data     (data1),
        .fill     (fill1)
    );

    assign any_full  = full0 | full1;
    assign both_full = full0 & full1;

    // Winner selection: lone slot wins; same register goes to the older slot;
    // otherwise alternate away from the last contended winner.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win = SRC_ALU;
        if (both_full) begin
            if (addr0 == addr1) begin
                win = older_is_1 ? SRC_MEM : SRC_ALU;
            end else begin
                win = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
            end
        end else if (full1) begin
            win = SRC_MEM;
        end
    end

    assign grant0 = any_full & (win == SRC_ALU);
    assign grant1 = any_full & (win == SRC_MEM);

    // Write port driven from the winning slot; x0 drains without a write.
    always_comb begin
        rf_wR = '0;
        rf_wD = '0;
        if (grant0) begin
            rf_wR = addr0;
            rf_wD = data0;
        end else if (grant1) begin
            rf_wR = addr1;
            rf_wD = data1;
        end
        rf_we = any_full & (rf_wR != '0);
    end

    // Pending-write mask: one-hot of each full slot's register, x0 excluded.
    always_comb begin
        busy_mask = '0;
        if (full0) busy_mask[addr0] = 1'b1;
        if (full1) busy_mask[addr1] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    // Age flag: the slot that stays full while the other (re)fills is the older one.
    // Simultaneous capture makes slot 1 older, since MEM precedes ALU in program order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_is_1 <= 1'b0;
        end else if (fill0 && fill1) begin
            older_is_1 <= 1'b1;
        end else if (fill0 && full1 && !grant1) begin
            older_is_1 <= 1'b1;
        end else if (fill1 && full0 && !grant0) begin
            older_is_1 <= 1'b0;
        end
    end

    // Round-robin pointer: only contended grants move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_MEM;
        end else if (both_full) begin
            last_grant <= win;
        end
    end

    // Saturating count of cycles with both slots occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (both_full && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: table of per-cycle vectors plus
// hand-written reset and sustained-contention sequences.
module tb_rf_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              s0_valid, s1_valid;
    logic              s0_ready, s1_ready;
    logic [AW-1:0]     s0_addr, s1_addr;
    logic [XLEN-1:0]   s0_data, s1_data;
    logic              rf_we;
    logic [AW-1:0]     rf_wR;
    logic [XLEN-1:0]   rf_wD;
    logic [2**AW-1:0]  busy_mask;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks   = 0;
    int failures = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s0_valid     (s0_valid),
        .s0_ready     (s0_ready),
        .s0_addr      (s0_addr),
        .s0_data      (s0_data),
        .s1_valid     (s1_valid),
        .s1_ready     (s1_ready),
        .s1_addr      (s1_addr),
        .s1_data      (s1_data),
        .rf_we        (rf_we),
        .rf_wR        (rf_wR),
        .rf_wD        (rf_wD),
        .busy_mask    (busy_mask),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            v0;
        logic [AW-1:0]   a0;
        logic [XLEN-1:0] d0;
        logic            v1;
        logic [AW-1:0]   a1;
        logic [XLEN-1:0] d1;
        logic            we;
        logic [AW-1:0]   wr;
        logic [XLEN-1:0] wd;
        logic [31:0]     busy;
        logic            r0;
        logic            r1;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v0, int a0, logic [31:0] d0,
                                logic v1, int a1, logic [31:0] d1,
                                logic we, int wr, logic [31:0] wd,
                                logic [31:0] busy, logic r0, logic r1, int cnt);
        vec_t v;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = d0;
        v.v1 = v1; v.a1 = AW'(a1); v.d1 = d1;
        v.we = we; v.wr = AW'(wr); v.wd = wd;
        v.busy = busy; v.r0 = r0; v.r1 = r1; v.cnt = CNT_W'(cnt);
        return v;
    endfunction

    function automatic logic [31:0] bit_of(int r);
        logic [31:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    endtask

    int writes;
    int alt_err;
    logic [AW-1:0] prev_wr;

    initial begin
        // Each row: inputs driven this cycle; outputs expected this cycle (state from prior edges).
        //              v0 a0  d0             v1 a1  d1             we wr  wd            busy                     r0 r1 cnt
        vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,                   1, 1, 0);
        vecs[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 5,  32'hDEADBEEF, bit_of(5),               1, 1, 0);
        vecs[2]  = mk(1, 3,  32'h11,       1, 4,  32'h22,       0, 0,  32'h0,        32'h0,                   1, 1, 0);
        vecs[3]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 3,  32'h11,       bit_of(3) | bit_of(4),   1, 0, 0);
        vecs[4]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 4,  32'h22,       bit_of(4),               1, 1, 1);
        vecs[5]  = mk(1, 3,  32'h33,       1, 4,  32'h44,       0, 0,  32'h0,        32'h0,                   1, 1, 1);
        vecs[6]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 4,  32'h44,       bit_of(3) | bit_of(4),   0, 1, 1);
        vecs[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 3,  32'h33,       bit_of(3),               1, 1, 2);
        vecs[8]  = mk(1, 7,  32'hAA,       0, 0,  32'h0,        0, 0,  32'h0,        32'h0,                   1, 1, 2);
        vecs[9]  = mk(0, 0,  32'h0,        1, 7,  32'hBB,       1, 7,  32'hAA,       bit_of(7),               1, 1, 2);
        vecs[10] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  32'hBB,       bit_of(7),               1, 1, 2);
        vecs[11] = mk(0, 0,  32'h0,        1, 0,  32'h1234,     0, 0,  32'h0,        32'h0,                   1, 1, 2);
        vecs[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h1234,     32'h0,                   1, 1, 2);
        vecs[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        32'h0,                   1, 1, 2);
        vecs[14] = mk(1, 9,  32'h55,       1, 9,  32'h66,       0, 0,  32'h0,        32'h0,                   1, 1, 2);
        vecs[15] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h66,       bit_of(9),               0, 1, 2);
        vecs[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h55,       bit_of(9),               1, 1, 3);
        vecs[17] = mk(1, 12, 32'h01,       1, 13, 32'h02,       0, 0,  32'h0,        32'h0,                   1, 1, 3);
        vecs[18] = mk(1, 13, 32'h03,       0, 0,  32'h0,        1, 12, 32'h01,       bit_of(12) | bit_of(13), 1, 0, 3);
        vecs[19] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 13, 32'h02,       bit_of(13),              0, 1, 4);
        vecs[20] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 13, 32'h03,       bit_of(13),              1, 1, 5);
        vecs[21] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        32'h0,                   1, 1, 5);

        // Reset state.
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset rf_we",     64'(rf_we),        64'h0);
        check("reset busy_mask", 64'(busy_mask),    64'h0);
        check("reset cnt",       64'(conflict_cnt), 64'h0);
        check("reset s0_ready",  64'(s0_ready),     64'h0);
        check("reset s1_ready",  64'(s1_ready),     64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            s0_valid = vecs[i].v0; s0_addr = vecs[i].a0; s0_data = vecs[i].d0;
            s1_valid = vecs[i].v1; s1_addr = vecs[i].a1; s1_data = vecs[i].d1;
            @(negedge clk);
            check($sformatf("row%0d rf_we", i),     64'(rf_we),        64'(vecs[i].we));
            check($sformatf("row%0d rf_wR", i),     64'(rf_wR),        64'(vecs[i].wr));
            check($sformatf("row%0d rf_wD", i),     64'(rf_wD),        64'(vecs[i].wd));
            check($sformatf("row%0d busy", i),      64'(busy_mask),    64'(vecs[i].busy));
            check($sformatf("row%0d s0_ready", i),  64'(s0_ready),     64'(vecs[i].r0));
            check($sformatf("row%0d s1_ready", i),  64'(s1_ready),     64'(vecs[i].r1));
            check($sformatf("row%0d cnt", i),       64'(conflict_cnt), 64'(vecs[i].cnt));
        end

        // Asynchronous reset with both slots full: buffered writes are discarded.
        @(posedge clk);
        #1;
        s0_valid = 1'b1; s0_addr = 5'd20; s0_data = 32'hA;
        s1_valid = 1'b1; s1_addr = 5'd21; s1_data = 32'hB;
        @(posedge clk);
        #1;
        check("pre-reset busy", 64'(busy_mask), 64'(bit_of(20) | bit_of(21)));
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst rf_we",    64'(rf_we),        64'h0);
        check("async rst busy",     64'(busy_mask),    64'h0);
        check("async rst cnt",      64'(conflict_cnt), 64'h0);
        check("async rst s0_ready", 64'(s0_ready),     64'h0);
        check("async rst s1_ready", 64'(s1_ready),     64'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post-reset%0d rf_we", i), 64'(rf_we),     64'h0);
            check($sformatf("post-reset%0d busy", i),  64'(busy_mask), 64'h0);
        end

        // Sustained contention: one write per cycle, alternating sources, counter saturates.
        @(posedge clk);
        #1;
        s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'h100;
        s1_valid = 1'b1; s1_addr = 5'd11; s1_data = 32'h200;
        @(posedge clk);
        writes  = 0;
        alt_err = 0;
        prev_wr = '0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (rf_we) writes++;
            if (i > 0 && rf_wR == prev_wr) alt_err++;
            prev_wr = rf_wR;
        end
        check("sustained writes",      64'(writes),       64'd70000);
        check("sustained alternation", 64'(alt_err),      64'd0);
        check("saturated cnt",         64'(conflict_cnt), 64'hFFFF);
        @(negedge clk);
        check("saturated cnt holds",   64'(conflict_cnt), 64'hFFFF);
        idle_inputs();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
